// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- four-requester round-robin arbiter with a bounded hold time.
//
// A requester keeps the grant for as long as it keeps requesting, unless
// another requester is waiting and the holder has already held it for
// MAX_HOLD cycles. Every release passes through one idle cycle. The priority
// pointer then moves to the requester after the one just released.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   enable      in   arbiter enable; no grant is issued while low
//   req[3:0]    in   request lines, bit i = requester i
//   grant[3:0]  out  registered one-hot grant (or all zeros)
//   grant_idx   out  registered binary index of the granted requester;
//                    holds its last value while no grant is active
//   grant_valid out  registered OR of the grant bits
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] grant_idx_q, grant_idx_d;
  logic       grant_valid_q, grant_valid_d;

  logic [7:0] req_rot_wide;
  logic [3:0] req_rot;
  logic [1:0] sel_off;
  logic [1:0] sel;
  logic       any_req;
  logic       other_req;
  logic       owner_req;
  logic       release_grant;

  // Rotate the requests so the pointer position is bit 0, then pick the lowest set bit.
  always_comb begin
    req_rot_wide = {req, req} >> ptr_q;
    req_rot      = req_rot_wide[3:0];
    if (req_rot[0]) begin
      sel_off = 2'd0;
    end else if (req_rot[1]) begin
      sel_off = 2'd1;
    end else if (req_rot[2]) begin
      sel_off = 2'd2;
    end else begin
      sel_off = 2'd3;
    end
    // The addition wraps modulo 4 because both operands are 2 bits wide.
    sel     = ptr_q + sel_off;
    any_req = |req;
  end

  // Release conditions for the active grant. Requests from others matter only at the hold limit.
  always_comb begin
    other_req     = |(req & ~grant_q);
    owner_req     = req[grant_idx_q];
    release_grant = !owner_req || !enable || ((hold_q == HOLD_LAST) && other_req);
  end

  // State register and all registered datapath and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      hold_q        <= 8'd0;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the pointer, the hold counter and the registered outputs.
  always_comb begin
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          grant_d       = 4'b0001 << sel;
          grant_idx_d   = sel;
          grant_valid_d = 1'b1;
          hold_d        = 8'd0;
        end else begin
          grant_d       = 4'b0000;
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          grant_d       = 4'b0000;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + 2'd1;
          hold_d        = 8'd0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end else begin
          // Saturated: the grant is held for as long as nobody else is waiting.
          hold_d = hold_q;
        end
      end
      default: begin
        ptr_d         = 2'd0;
        hold_d        = 8'd0;
        grant_d       = 4'b0000;
        grant_idx_d   = 2'd0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4. A behavioural model predicts the outputs for
// each driven cycle. The prediction is queued and compared after the edge.
// Fixed expectations are checked alongside the model for the key scenarios.
module tb_rr_arbiter_4;
  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] exp_q[$];

  // Model state
  bit m_busy;
  int m_ptr;
  int m_hold;
  int m_idx;

  rr_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_hold = 0;
    m_idx  = 0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] rq);
    bit   found;
    int   j;
    logic [3:0] others;
    if (!m_busy) begin
      if (en && rq != 4'b0000) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (!found && rq[j]) begin
            found = 1'b1;
            m_idx = j;
          end
        end
        m_busy = 1'b1;
        m_hold = 0;
      end
    end else begin
      others = rq & ~(4'b0001 << m_idx);
      if (!rq[m_idx] || !en || (m_hold == MAXH - 1 && others != 4'b0000)) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % 4;
      end else if (m_hold < MAXH - 1) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic cycle(input logic en, input logic [3:0] rq);
    logic [6:0] e;
    @(negedge clk);
    enable = en;
    req    = rq;
    model_step(en, rq);
    exp_q.push_back({(m_busy ? (4'b0001 << m_idx) : 4'b0000), 2'(m_idx), m_busy});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb_grant", 32'(grant), 32'(e[6:3]));
    check_eq("sb_idx", 32'(grant_idx), 32'(e[2:1]));
    check_eq("sb_valid", 32'(grant_valid), 32'(e[0]));
    check_eq("onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  // Pulse reset between edges and check that it acts without a clock edge.
  task automatic pulse_reset();
    #1;
    reset = 1'b1;
    #2;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_valid", 32'(grant_valid), 32'd0);
    check_eq("rst_idx", 32'(grant_idx), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] exp_g;
    reset  = 1'b1;
    enable = 1'b0;
    req    = 4'b0000;
    model_reset();
    #3;
    check_eq("por_grant", 32'(grant), 32'd0);
    check_eq("por_idx", 32'(grant_idx), 32'd0);
    check_eq("por_valid", 32'(grant_valid), 32'd0);
    reset = 1'b0;

    // Single requester, then release; the pointer moves to 3
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 4'b0100);
      check_eq("single_grant", 32'(grant), 32'h4);
      check_eq("single_idx", 32'(grant_idx), 32'h2);
    end
    cycle(1'b1, 4'b0000);
    check_eq("single_release", 32'(grant), 32'h0);
    cycle(1'b1, 4'b1111);
    check_eq("ptr_after_single", 32'(grant), 32'h8);
    pulse_reset();

    // Round robin with every requester active
    for (int c = 0; c < 37; c++) begin
      cycle(1'b1, 4'b1111);
      exp_g = (c % 9 == 8) ? 4'b0000 : (4'b0001 << ((c / 9) % 4));
      check_eq("rr_seq", 32'(grant), 32'(exp_g));
    end
    pulse_reset();

    // Hold limit with two requesters
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 4'b0011);
      exp_g = (c < 8) ? 4'b0001 : ((c == 8) ? 4'b0000 : 4'b0010);
      check_eq("hold_limit", 32'(grant), 32'(exp_g));
    end
    pulse_reset();

    // Dropping enable releases the grant and still advances the pointer
    cycle(1'b1, 4'b0010);
    check_eq("en_pre", 32'(grant), 32'h2);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 4'b0010);
      check_eq("en_low", 32'(grant), 32'h0);
    end
    cycle(1'b1, 4'b0011);
    check_eq("reen_wrap", 32'(grant), 32'h1);
    pulse_reset();

    // Asynchronous reset in the middle of a grant
    cycle(1'b1, 4'b1000);
    cycle(1'b1, 4'b1000);
    check_eq("mid_pre", 32'(grant), 32'h8);
    pulse_reset();
    cycle(1'b1, 4'b1001);
    check_eq("post_rst", 32'(grant), 32'h1);

    // No requests: no grant, and the index holds its last value
    cycle(1'b1, 4'b0000);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 4'b0000);
      check_eq("idle_grant", 32'(grant), 32'h0);
      check_eq("idle_idx", 32'(grant_idx), 32'h0);
    end

    // With no competing request, the grant continues past the hold limit
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, 4'b0100);
    end

    // Random traffic against the model
    for (int c = 0; c < 300; c++) begin
      cycle(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
